// File: rtl/multiplier_seq.sv
// Sequential shift-add multiplier: one multiplier bit per clock, fixed WIDTH+1 cycle latency.
// Define MULT_SIGNED_EN for two's-complement operands; the default build is unsigned.
module multiplier_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand_sh;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   mcand_ext;
  logic [CW-1:0]        cnt;
  logic                 last;
  logic                 load;

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MULT_SIGNED_EN
  // The multiplier MSB carries weight -2^(WIDTH-1), so the final partial product is subtracted.
  assign mcand_ext = {{WIDTH{in1[WIDTH-1]}}, in1};
  always_comb begin
    addend = '0;
    if (mplier[0]) addend = last ? (~mcand_sh + 1'b1) : mcand_sh;
  end
`else
  assign mcand_ext = {{WIDTH{1'b0}}, in1};
  always_comb begin
    addend = '0;
    if (mplier[0]) addend = mcand_sh;
  end
`endif

  assign acc_nxt = acc + addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_sh <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      p        <= '0;
    end else if (load) begin
      mcand_sh <= mcand_ext;
      mplier   <= in2;
      acc      <= '0;
      cnt      <= '0;
    end else if (state == RUN) begin
      acc      <= acc_nxt;
      mcand_sh <= mcand_sh << 1;
      mplier   <= mplier >> 1;
      cnt      <= cnt + 1'b1;
      if (last) p <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed self-checking bench for multiplier_seq at WIDTH=4 (signed vectors when MULT_SIGNED_EN is defined).
module tb_multiplier_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] in1;
  logic [3:0] in2;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int unsigned vec;
  int unsigned miss;

  multiplier_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive operands and take the accepting edge; operands are then scrambled.
  task automatic accept(input logic [3:0] a, input logic [3:0] b);
    in1   = a;
    in2   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    in1   = ~a;
    in2   = ~b;
  endtask

  // Four busy cycles then the done cycle; optionally hammer start with 9*9 while busy.
  task automatic run_check(input string tag, input logic [7:0] exp, input bit hammer);
    for (int i = 0; i < 4; i++) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " no done"}, {31'd0, done}, 32'd0);
      if (hammer) begin
        start = 1'b1;
        in1   = 4'd9;
        in2   = 4'd9;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy low"}, {31'd0, busy}, 32'd0);
    chk({tag, " p"}, {24'd0, p}, {24'd0, exp});
  endtask

  task automatic idle_check(input string tag, input logic [7:0] exp);
    tick();
    chk({tag, " done drop"}, {31'd0, done}, 32'd0);
    chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " p hold"}, {24'd0, p}, {24'd0, exp});
  endtask

  initial begin
    vec   = 0;
    miss  = 0;
    rst   = 1'b1;
    start = 1'b1;
    in1   = 4'd3;
    in2   = 4'd3;
    tick();
    tick();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst p", {24'd0, p}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    tick();

`ifdef MULT_SIGNED_EN
    accept(4'h8, 4'h8);
    run_check("s -8*-8", 8'h40, 1'b0);
    idle_check("s -8*-8", 8'h40);
    accept(4'h8, 4'h7);
    run_check("s -8*7", 8'hC8, 1'b0);
    idle_check("s -8*7", 8'hC8);
    accept(4'hF, 4'h1);
    run_check("s -1*1", 8'hFF, 1'b0);
    idle_check("s -1*1", 8'hFF);
    accept(4'h3, 4'hB);
    run_check("s 3*-5", 8'hF1, 1'b0);
    idle_check("s 3*-5", 8'hF1);
`else
    accept(4'd15, 4'd15);
    run_check("15*15", 8'hE1, 1'b0);
    idle_check("15*15", 8'hE1);
    tick();
    chk("15*15 p hold2", {24'd0, p}, 32'hE1);

    accept(4'd8, 4'd7);
    run_check("8*7", 8'h38, 1'b0);
    idle_check("8*7", 8'h38);

    accept(4'd0, 4'd13);
    run_check("0*13", 8'h00, 1'b0);
    idle_check("0*13", 8'h00);

    accept(4'd3, 4'd5);
    run_check("3*5 ignore", 8'h0F, 1'b1);
    idle_check("3*5 ignore", 8'h0F);
`endif

    // Back-to-back: start held across the DONE cycle.
    accept(4'd2, 4'd3);
    run_check("b2b 2*3", 8'h06, 1'b0);
    accept(4'd6, 4'd6);
    run_check("b2b 6*6", 8'h24, 1'b0);
    idle_check("b2b 6*6", 8'h24);

    // Reset two cycles into an operation aborts it.
    accept(4'd15, 4'd15);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort p", {24'd0, p}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort no done", {31'd0, done}, 32'd0);
      chk("abort no busy", {31'd0, busy}, 32'd0);
    end
    accept(4'd5, 4'd5);
    run_check("5*5", 8'h19, 1'b0);
    idle_check("5*5", 8'h19);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/multiplier_seq.md
MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new multiplication.
REQ-005 SHALL have port in1, input, WIDTH bits: multiplicand, sampled only when start is accepted.
REQ-006 SHALL have port in2, input, WIDTH bits: multiplier, sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking p valid for a new result.
REQ-009 SHALL have port p, output, 2*WIDTH bits: product, registered.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 IDLE: busy=0, done=0; start=1 at an edge latches in1/in2, clears the accumulator and bit counter, and moves to RUN.
REQ-012 RUN: busy=1, done=0; each edge processes one multiplier bit (shift-add: add the multiplicand to the accumulator when the current bit is 1, then shift); the counter increments.
REQ-013 After exactly WIDTH RUN edges, the FSM SHALL move to DONE and load the final product into p on that same edge.
REQ-014 DONE: busy=0, done=1 for exactly one cycle; the next edge moves to RUN if start=1 (back-to-back), otherwise to IDLE.
REQ-015 Latency SHALL be fixed: done is high in the cycle starting WIDTH+1 edges after the accepting edge, independent of operand values, including zero operands.
REQ-016 start while busy=1 SHALL be ignored; the operands in flight SHALL NOT change.
REQ-017 in1/in2 changes after the accepting edge SHALL NOT affect the result.
REQ-018 p SHALL hold the last result until the next DONE entry; p SHALL NOT show intermediate accumulator values.
REQ-019 The product SHALL be exact over the full 2*WIDTH bits, with no truncation or overflow; e.g. WIDTH=4 gives max 15*15=225.

Reset
REQ-020 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, p=0, and clear the accumulator and counter; rst has priority over start.
REQ-021 Reset mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-022 Macro MULT_SIGNED_EN defined: in1/in2 SHALL be two's-complement; p SHALL equal the signed 2*WIDTH-bit product with identical latency and handshake (the sign-handling method is free).
REQ-023 Macro MULT_SIGNED_EN undefined: in1/in2 SHALL be unsigned; p SHALL equal the unsigned product; no sign logic SHALL be synthesised.

Verification (WIDTH=4)
REQ-024 Unsigned: rst pulse, then start with in1=15, in2=15 -> busy high for 4 cycles, done pulses 5 cycles after the accepting edge, p=8'hE1 (225), and p holds after done.
REQ-025 Unsigned: in1=8, in2=7 -> p=8'h38; in1=0, in2=13 -> p=8'h00 with the same 5-cycle latency.
REQ-026 Start asserted in the cycles after the start accepted for 3*5, with in1=9, in2=9 while busy -> ignored; p=8'h0F.
REQ-027 Back-to-back: start held high across the DONE cycle with 2*3 then 6*6 -> done pulses 5 cycles apart, giving p=8'h06 then p=8'h24.
REQ-028 rst asserted 2 cycles into 15*15 -> no done pulse, p=0, busy=0; then 5*5 -> p=8'h19.
REQ-029 MULT_SIGNED_EN: -8*-8 -> p=8'h40; -8*7 -> p=8'hC8 (-56); -1*1 -> p=8'hFF.
